// File: rtl/btn_pkg.sv
// Shared definitions for the push-button strobe generator: repeat FSM
// states, default timing constants and the counter width helper.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } rpt_state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 500000;
   localparam int DEF_REPEAT_DELAY    = 25000000;
   localparam int DEF_REPEAT_RATE     = 5000000;
   localparam int DEF_CLEAR_CYCLES    = 100000000;

   // Bits needed to hold 0..n-1; never less than one bit.
   function automatic int cnt_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/button_strobe_gen_if.sv
// Button-side and counter-side signals of the strobe generator.
// The slave view is the generator itself, the master view its environment.
interface button_strobe_gen_if;

   logic btn_up_raw;
   logic btn_dn_raw;
   logic up_n;
   logic dn_n;
   logic clr_n;
   logic up_held;
   logic dn_held;

   modport master (
      output btn_up_raw,
      output btn_dn_raw,
      input  up_n,
      input  dn_n,
      input  clr_n,
      input  up_held,
      input  dn_held
   );

   modport slave (
      input  btn_up_raw,
      input  btn_dn_raw,
      output up_n,
      output dn_n,
      output clr_n,
      output up_held,
      output dn_held
   );

endinterface

// File: rtl/btn_debounce_repeat.sv
// One button: two-flop synchroniser, debounce filter and auto-repeat FSM.
// held is the debounced pressed level; evt marks a press or repeat event
// for one cycle and rpt tells the two apart (1 = repeat).
module btn_debounce_repeat
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic held,
   output logic evt,
   output logic rpt
);

   localparam int DB_W  = cnt_w(DEBOUNCE_CYCLES);
   localparam int TMR_W = (cnt_w(REPEAT_DELAY) > cnt_w(REPEAT_RATE)) ?
                          cnt_w(REPEAT_DELAY) : cnt_w(REPEAT_RATE);

   localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMR_W-1:0] DLY_LOAD  = TMR_W'(REPEAT_DELAY - 1);
   localparam logic [TMR_W-1:0] RATE_LOAD = TMR_W'(REPEAT_RATE - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic             pressed;
   logic             stable_q;
   logic [DB_W-1:0]  db_cnt_q;
   rpt_state_t       state_q;
   rpt_state_t       state_d;
   logic [TMR_W-1:0] timer_q;
   logic [TMR_W-1:0] timer_d;

   // Stage p0/p1: bring the raw level into the clk domain; idles released.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
      end else begin
         sync_p0 <= btn_raw;
         sync_p1 <= sync_p0;
      end
   end

   assign pressed = ~sync_p1;

   // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable_q <= 1'b0;
         db_cnt_q <= '0;
      end else if (pressed == stable_q) begin
         db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
         stable_q <= ~stable_q;
         db_cnt_q <= '0;
      end else begin
         db_cnt_q <= db_cnt_q + DB_W'(1);
      end
   end

   assign held = stable_q;

   // Repeat FSM state and timer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   // Press event on debounced rise, then delayed and periodic repeats while held.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      evt     = 1'b0;
      rpt     = 1'b0;
      case (state_q)
         IDLE: begin
            // In IDLE a set stable level can only mean it has just risen.
            if (stable_q) begin
               evt     = 1'b1;
               timer_d = DLY_LOAD;
               state_d = DELAY;
            end
         end
         DELAY, REPEAT: begin
            if (!stable_q) begin
               timer_d = '0;
               state_d = IDLE;
            end else if (timer_q == '0) begin
               evt     = 1'b1;
               rpt     = 1'b1;
               timer_d = RATE_LOAD;
               state_d = REPEAT;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         default: begin
            timer_d = '0;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: rtl/button_strobe_gen.sv
// Turns the raw up/down push-buttons into active-low count strobes and a
// both-held clear for the decade counter chain.
module button_strobe_gen
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
   parameter int CLEAR_CYCLES    = DEF_CLEAR_CYCLES
) (
   input logic               clk,
   input logic               rst,
   button_strobe_gen_if.slave bus
);

   localparam int               CLR_W    = cnt_w(CLEAR_CYCLES);
   localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

   logic             up_held;
   logic             dn_held;
   logic             up_evt;
   logic             dn_evt;
   logic             up_rpt;
   logic             dn_rpt;
   logic             both_held;
   logic             up_ok;
   logic             dn_ok;
   logic             up_go;
   logic             dn_go;
   logic             clr_fire;
   logic [CLR_W-1:0] clr_cnt_q;
   logic             clr_done_q;
   logic             up_n_q;
   logic             dn_n_q;
   logic             clr_n_q;

   btn_debounce_repeat #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
   ) u_up (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (bus.btn_up_raw),
      .held    (up_held),
      .evt     (up_evt),
      .rpt     (up_rpt)
   );

   btn_debounce_repeat #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
   ) u_dn (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (bus.btn_dn_raw),
      .held    (dn_held),
      .evt     (dn_evt),
      .rpt     (dn_rpt)
   );

   // Repeats are muted while both are held; coincident events cancel out.
   assign both_held = up_held & dn_held;
   assign up_ok     = up_evt & ~(both_held & up_rpt);
   assign dn_ok     = dn_evt & ~(both_held & dn_rpt);
   assign up_go     = up_ok & ~dn_ok;
   assign dn_go     = dn_ok & ~up_ok;

   // Clear fires once when the both-held count reaches its last value.
   assign clr_fire  = both_held & (clr_cnt_q == CLR_LAST) & ~clr_done_q;

   // Count both-held cycles, parking at the last value until a release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_cnt_q  <= '0;
         clr_done_q <= 1'b0;
      end else if (!both_held) begin
         clr_cnt_q  <= '0;
         clr_done_q <= 1'b0;
      end else if (clr_cnt_q == CLR_LAST) begin
         clr_done_q <= 1'b1;
      end else begin
         clr_cnt_q  <= clr_cnt_q + CLR_W'(1);
      end
   end

   // Output stage: registered active-low strobes, idle high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         up_n_q  <= 1'b1;
         dn_n_q  <= 1'b1;
         clr_n_q <= 1'b1;
      end else begin
         up_n_q  <= ~up_go;
         dn_n_q  <= ~dn_go;
         clr_n_q <= ~clr_fire;
      end
   end

   assign bus.up_n    = up_n_q;
   assign bus.dn_n    = dn_n_q;
   assign bus.clr_n   = clr_n_q;
   assign bus.up_held = up_held;
   assign bus.dn_held = dn_held;

endmodule

// File: tb/tb_button_strobe_gen.sv
// Bench for button_strobe_gen: directed scenarios followed by random button
// activity, every cycle compared against a timing-rule reference model.
module tb_button_strobe_gen;

   localparam int DB = 4;
   localparam int RD = 20;
   localparam int RR = 5;
   localparam int CC = 50;

   logic clk;
   logic rst;

   button_strobe_gen_if bus ();

   button_strobe_gen #(
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_RATE     (RR),
      .CLEAR_CYCLES    (CC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model state: raw level history, accepted level, time of rise.
   logic m_s1 [2];
   logic m_s2 [2];
   logic m_stable [2];
   int   m_run [2];
   int   m_rise [2];
   int   m_both_since;
   int   cyc;
   logic e_up_n;
   logic e_dn_n;
   logic e_clr_n;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // A held button strobes one cycle after acceptance, then RD later, then every RR.
   function automatic bit strobe_due(input int age);
      return (age == 1) || (age >= 1 + RD && ((age - 1 - RD) % RR) == 0);
   endfunction

   task automatic model_reset();
      for (int b = 0; b < 2; b++) begin
         m_s1[b]     = 1'b1;
         m_s2[b]     = 1'b1;
         m_stable[b] = 1'b0;
         m_run[b]    = 0;
         m_rise[b]   = 0;
      end
      m_both_since = 0;
      e_up_n  = 1'b1;
      e_dn_n  = 1'b1;
      e_clr_n = 1'b1;
   endtask

   task automatic model_edge();
      logic raw_now [2];
      logic ev [2];
      logic both_old;
      logic fu;
      logic fd;
      logic clr;
      int   age;
      raw_now[0] = bus.btn_up_raw;
      raw_now[1] = bus.btn_dn_raw;
      cyc++;
      both_old = m_stable[0] && m_stable[1];
      for (int b = 0; b < 2; b++) begin
         age   = cyc - m_rise[b];
         ev[b] = m_stable[b] && strobe_due(age);
         if (both_old && age > 1) ev[b] = 1'b0;
      end
      fu  = ev[0] && !ev[1];
      fd  = ev[1] && !ev[0];
      clr = both_old && (cyc - m_both_since == CC);
      for (int b = 0; b < 2; b++) begin
         if ((!m_s2[b]) != m_stable[b]) begin
            m_run[b]++;
            if (m_run[b] == DB) begin
               m_stable[b] = !m_s2[b];
               m_run[b]    = 0;
               if (m_stable[b]) m_rise[b] = cyc;
            end
         end else begin
            m_run[b] = 0;
         end
         m_s2[b] = m_s1[b];
         m_s1[b] = raw_now[b];
      end
      if (m_stable[0] && m_stable[1] && !both_old) m_both_since = cyc;
      e_up_n  = !fu;
      e_dn_n  = !fd;
      e_clr_n = !clr;
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) model_reset();
      else model_edge();
      #1;
      chk("up_n",    bus.up_n,    e_up_n);
      chk("dn_n",    bus.dn_n,    e_dn_n);
      chk("clr_n",   bus.clr_n,   e_clr_n);
      chk("up_held", bus.up_held, m_stable[0]);
      chk("dn_held", bus.dn_held, m_stable[1]);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_up_n"},    bus.up_n,    1);
      chk({tag, "_dn_n"},    bus.dn_n,    1);
      chk({tag, "_clr_n"},   bus.clr_n,   1);
      chk({tag, "_up_held"}, bus.up_held, 0);
      chk({tag, "_dn_held"}, bus.dn_held, 0);
   endtask

   initial begin
      int first_low;
      int first_held;
      int first_clr;
      int up_cnt;
      int dn_cnt;
      int clr_cnt;
      int dn_held_seen;
      int q [$];
      int run_left [2];
      logic lvl [2];

      cyc = 0;
      rst = 1'b1;
      bus.btn_up_raw = 1'b1;
      bus.btn_dn_raw = 1'b1;
      model_reset();
      step();
      step();
      check_reset_outputs("reset");
      rst = 1'b0;
      for (int i = 0; i < 4; i++) step();

      // Clean press held 10 cycles.
      first_low = -1; first_held = -1; up_cnt = 0; dn_cnt = 0;
      bus.btn_up_raw = 1'b0;
      for (int i = 0; i < 25; i++) begin
         if (i == 10) bus.btn_up_raw = 1'b1;
         step();
         if (bus.up_n === 1'b0) begin up_cnt++; if (first_low < 0) first_low = i; end
         if (bus.dn_n === 1'b0) dn_cnt++;
         if (bus.up_held === 1'b1 && first_held < 0) first_held = i;
      end
      chk("press_strobe_offset", first_low, 6);
      chk("press_held_offset", first_held, 5);
      chk("press_up_count", up_cnt, 1);
      chk("press_dn_count", dn_cnt, 0);

      // Bouncing down button never accepted.
      dn_cnt = 0; dn_held_seen = 0;
      for (int i = 0; i < 35; i++) begin
         bus.btn_dn_raw = (i < 20) ? logic'((i / 2) % 2) : 1'b1;
         step();
         if (bus.dn_n === 1'b0) dn_cnt++;
         if (bus.dn_held === 1'b1) dn_held_seen++;
      end
      chk("bounce_dn_count", dn_cnt, 0);
      chk("bounce_dn_held", dn_held_seen, 0);

      // Auto-repeat on a long up hold.
      q.delete();
      bus.btn_up_raw = 1'b0;
      for (int i = 0; i < 85; i++) begin
         if (i == 66) bus.btn_up_raw = 1'b1;
         step();
         if (bus.up_n === 1'b0) q.push_back(i);
      end
      chk("repeat_count", q.size(), 11);
      chk("repeat_first", (q.size() > 0) ? q[0] : -1, 6);
      chk("repeat_second", (q.size() > 1) ? q[1] : -1, 26);
      chk("repeat_third", (q.size() > 2) ? q[2] : -1, 31);
      chk("repeat_last", (q.size() > 0) ? q[q.size() - 1] : -1, 71);

      // Both buttons pressed on the same edge.
      up_cnt = 0; dn_cnt = 0; clr_cnt = 0; first_clr = -1;
      bus.btn_up_raw = 1'b0;
      bus.btn_dn_raw = 1'b0;
      for (int i = 0; i < 170; i++) begin
         if (i == 150) begin bus.btn_up_raw = 1'b1; bus.btn_dn_raw = 1'b1; end
         step();
         if (bus.up_n === 1'b0) up_cnt++;
         if (bus.dn_n === 1'b0) dn_cnt++;
         if (bus.clr_n === 1'b0) begin clr_cnt++; if (first_clr < 0) first_clr = i; end
      end
      chk("both_up_count", up_cnt, 0);
      chk("both_dn_count", dn_cnt, 0);
      chk("both_clr_count", clr_cnt, 1);
      chk("both_clr_offset", first_clr, 55);

      // Reset while up is repeating, button kept down across reset.
      bus.btn_up_raw = 1'b0;
      for (int i = 0; i < 42; i++) step();
      chk("rpt_low_before_rst", bus.up_n, 0);
      rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      model_reset();
      step();
      step();
      rst = 1'b0;
      first_low = -1; first_held = -1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.up_n === 1'b0 && first_low < 0) first_low = i;
         if (bus.up_held === 1'b1 && first_held < 0) first_held = i;
      end
      chk("post_rst_strobe_offset", first_low, 6);
      chk("post_rst_held_offset", first_held, 5);
      bus.btn_up_raw = 1'b1;
      for (int i = 0; i < 10; i++) step();

      // Random button activity with occasional resets.
      lvl[0] = 1'b1; lvl[1] = 1'b1;
      run_left[0] = 3; run_left[1] = 7;
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < 2; b++) begin
            if (run_left[b] == 0) begin
               lvl[b] = ~lvl[b];
               run_left[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5))
                                                         : int'($urandom_range(8, 140));
            end
            run_left[b]--;
         end
         bus.btn_up_raw = lvl[0];
         bus.btn_dn_raw = lvl[1];
         if (rst) begin
            rst = 1'b0;
         end else if ($urandom_range(0, 699) == 0) begin
            rst = 1'b1;
            #1;
            check_reset_outputs("rand_rst");
            model_reset();
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
